dmem_lsu: RTL
=============

# dmem_lsu

Load/store unit for the RISC-V pipelined core; it is the initiator side of the data-memory port. It takes one load or store request at a time from the MEM stage and drives the word-addressed data memory (word index, write data, write enable, combinational read data). Byte and halfword loads are extracted with sign or zero extension. Byte and halfword stores are done as a read-modify-write, because the memory only writes whole words.

## Interface
Parameters:
- DMEM_WORDS, 256: memory depth in 32-bit words. Legal byte addresses are 0 .. 4*DMEM_WORDS-1.
- IDX_W, 8: width of the word index, log2(DMEM_WORDS).

Ports:
- clk  in  1  rising-edge clock.
- rst_n  in  1  asynchronous, active-low reset.
- req_valid  in  1  request present.
- req_ready  out  1  unit can accept a request this cycle.
- req_we  in  1  1 = store, 0 = load.
- req_funct3  in  3  RISC-V funct3. Loads: 000 LB, 001 LH, 010 LW, 100 LBU, 101 LHU. Stores: 000 SB, 001 SH, 010 SW.
- req_addr  in  32  byte address.
- req_wdata  in  32  store data, right-aligned.
- resp_valid  out  1  one-cycle completion pulse.
- resp_rdata  out  32  load result, extended. 0 for stores and errors.
- resp_err  out  1  misaligned, out-of-range or illegal funct3. Qualified by resp_valid.
- m_addr  out  IDX_W  word index, equal to req_addr[IDX_W+1:2].
- m_wdata  out  32  memory write data.
- m_we  out  1  memory write enable, sampled at the rising clk edge.
- m_rdata  in  32  memory read data, combinational from m_addr.

## Operation
- States: IDLE, LOAD, WRITE, RMW_RD, RMW_WR.
- req_ready = (state == IDLE). A request is accepted on a clk edge where req_valid and req_ready are both 1.
- On acceptance, funct3, addr and wdata are captured. Captured values are held until the response.
- Error checks on acceptance:
  - Illegal funct3 (loads 011/110/111, stores 011 and above) is an error.
  - Misaligned: halfword access with addr[0]=1, or word access with addr[1:0]≠0.
  - Out of range: addr ≥ 4*DMEM_WORDS.
  - On error: stay in IDLE, pulse resp_valid with resp_err=1 on the next cycle, make no memory access.
- Transitions from IDLE on acceptance:
  - Load goes to LOAD.
  - SW goes to WRITE.
  - SB/SH go to RMW_RD.
- LOAD: drive m_addr with m_we=0. At the end of the cycle, register the selected lane of m_rdata into resp_rdata, then go to IDLE.
  - Byte lane = addr[1:0]; halfword lane = addr[1].
  - LB/LH sign-extend; LBU/LHU zero-extend.
- WRITE: m_we=1, m_wdata = wdata. Then go to IDLE.
- RMW_RD: drive m_addr with m_we=0 and capture m_rdata into an old-word register. Then go to RMW_WR.
- RMW_WR: m_we=1. m_wdata = old word with the addressed byte or halfword replaced by wdata[7:0] or wdata[15:0]; other lanes unchanged. Then go to IDLE.
- resp_valid is registered. It pulses for one cycle in the IDLE cycle that follows the final state. resp_err=0 for successful accesses.
- m_addr, m_wdata and m_we are driven only from registered state. In IDLE: m_we=0, m_addr=0, m_wdata=0.
- Back-to-back: a new request may be accepted in the same cycle that resp_valid is high.

## Timing
- Request accepted at edge E0, so the unit is busy from E0.
- Load: LOAD occupies cycle E0–E1. resp_valid is high E1–E2. Latency is 2 edges.
- SW: memory write commits at E1. resp_valid is high E1–E2.
- SB/SH: read in E0–E1, write commits at E2. resp_valid is high E2–E3. Latency is 3 edges.
- Error: resp_valid is high E0–E1. req_ready stays 1.
- req_valid is ignored while req_ready=0. Request inputs may change freely while busy.
- Reset values while rst_n=0: state IDLE, req_ready=1, resp_valid=0, resp_rdata=0, resp_err=0, m_we=0, m_addr=0, m_wdata=0.
- Reset mid-operation aborts immediately. m_we falls asynchronously, so no write commits at any edge while rst_n=0. No response is issued for the aborted request.

## Test plan
- SW then LW: SW addr 0x10, data 0xDEADBEEF. Expect m_we=1 with m_addr=4, resp_valid 2 edges after acceptance. Then LW 0x10: resp_rdata=0xDEADBEEF 2 edges after acceptance.
- Sign/zero extension: memory word 0 holds 0x80FF7F01.
  - LB 0x1 → 0x0000007F.
  - LB 0x2 → 0xFFFFFFFF.
  - LBU 0x3 → 0x00000080.
  - LH 0x2 → 0xFFFF80FF.
  - LHU 0x2 → 0x000080FF.
- SB into a known word: word 2 = 0x11223344; SB addr 0x9, data 0xAA. Expect one read cycle, then a write of 0x1122AA44 with resp_valid 3 edges after acceptance. A following SH 0xA, data 0xBEEF must give 0xBEEFAA44.
- Errors: LW 0x6, SH 0x3, LB 0x400, funct3 011 load. Each gives resp_valid with resp_err=1 one edge after acceptance, m_we never asserts, and req_ready stays 1.
- Back-to-back: LW issued in the resp_valid cycle of a previous SB is accepted there, and completes 2 edges later with the post-SB data.
- Reset mid-RMW: SB accepted, rst_n pulled low in the RMW_RD cycle. The target word is unchanged, no resp_valid appears, and all outputs hold their reset values.

Source files
------------

// File: rtl/dmem_lsu.sv
// Load/store unit driving a word-addressed data memory with combinational read data.
// Sub-word loads are lane-extracted and extended; sub-word stores use read-modify-write.
module dmem_lsu #(
  parameter int DMEM_WORDS = 256,
  parameter int IDX_W      = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic             req_we,
  input  logic [2:0]       req_funct3,
  input  logic [31:0]      req_addr,
  input  logic [31:0]      req_wdata,
  output logic             resp_valid,
  output logic [31:0]      resp_rdata,
  output logic             resp_err,
  output logic [IDX_W-1:0] m_addr,
  output logic [31:0]      m_wdata,
  output logic             m_we,
  input  logic [31:0]      m_rdata
);

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_LOAD   = 3'd1;
  localparam logic [2:0] S_WRITE  = 3'd2;
  localparam logic [2:0] S_RMW_RD = 3'd3;
  localparam logic [2:0] S_RMW_WR = 3'd4;

  localparam logic [31:0] ADDR_LIMIT = 32'(4 * DMEM_WORDS);

  logic [2:0]       state_q, state_d;
  logic [2:0]       f3_q, f3_d;
  logic [1:0]       lo_q, lo_d;
  logic [15:0]      wdata_q, wdata_d;
  logic             resp_valid_q, resp_valid_d;
  logic             resp_err_q, resp_err_d;
  logic [31:0]      resp_rdata_q, resp_rdata_d;
  logic [IDX_W-1:0] m_addr_q, m_addr_d;
  logic [31:0]      m_wdata_q, m_wdata_d;
  logic             m_we_q, m_we_d;

  logic accept_s, f3_bad_s, misal_s, range_s, err_s;

  function automatic logic [31:0] load_extract(input logic [2:0] f3, input logic [1:0] lo,
                                               input logic [31:0] word);
    logic [7:0]  b;
    logic [15:0] h;
    case (lo)
      2'd0:    b = word[7:0];
      2'd1:    b = word[15:8];
      2'd2:    b = word[23:16];
      2'd3:    b = word[31:24];
      default: b = 8'd0;
    endcase
    h = lo[1] ? word[31:16] : word[15:0];
    case (f3)
      3'b000:  load_extract = {{24{b[7]}}, b};
      3'b001:  load_extract = {{16{h[15]}}, h};
      3'b010:  load_extract = word;
      3'b100:  load_extract = {24'd0, b};
      3'b101:  load_extract = {16'd0, h};
      default: load_extract = 32'd0;
    endcase
  endfunction

  function automatic logic [31:0] store_merge(input logic is_half, input logic [1:0] lo,
                                              input logic [31:0] old, input logic [15:0] wd);
    logic [31:0] w;
    w = old;
    if (is_half) begin
      if (lo[1]) w[31:16] = wd;
      else       w[15:0]  = wd;
    end else begin
      case (lo)
        2'd0:    w[7:0]   = wd[7:0];
        2'd1:    w[15:8]  = wd[7:0];
        2'd2:    w[23:16] = wd[7:0];
        2'd3:    w[31:24] = wd[7:0];
        default: w = old;
      endcase
    end
    store_merge = w;
  endfunction

  // Request decode and error classification
  always_comb begin
    accept_s = req_valid && (state_q == S_IDLE);
    if (req_we) begin
      f3_bad_s = (req_funct3 > 3'b010);
    end else begin
      f3_bad_s = (req_funct3 == 3'b011) || (req_funct3[2:1] == 2'b11);
    end
    case (req_funct3[1:0])
      2'b01:   misal_s = req_addr[0];
      2'b10:   misal_s = (req_addr[1:0] != 2'b00);
      default: misal_s = 1'b0;
    endcase
    range_s = (req_addr >= ADDR_LIMIT);
    err_s   = f3_bad_s || misal_s || range_s;
  end

  // Next-state and output-register logic
  always_comb begin
    state_d      = state_q;
    f3_d         = f3_q;
    lo_d         = lo_q;
    wdata_d      = wdata_q;
    resp_valid_d = 1'b0;
    resp_err_d   = 1'b0;
    resp_rdata_d = 32'd0;
    m_addr_d     = m_addr_q;
    m_wdata_d    = m_wdata_q;
    m_we_d       = 1'b0;
    case (state_q)
      S_IDLE: begin
        m_addr_d  = '0;
        m_wdata_d = 32'd0;
        if (accept_s) begin
          f3_d    = req_funct3;
          lo_d    = req_addr[1:0];
          wdata_d = req_wdata[15:0];
          if (err_s) begin
            resp_valid_d = 1'b1;
            resp_err_d   = 1'b1;
          end else begin
            m_addr_d = req_addr[IDX_W+1:2];
            if (!req_we) begin
              state_d = S_LOAD;
            end else if (req_funct3 == 3'b010) begin
              state_d   = S_WRITE;
              m_we_d    = 1'b1;
              m_wdata_d = req_wdata;
            end else begin
              state_d = S_RMW_RD;
            end
          end
        end else begin
          state_d = S_IDLE;
        end
      end
      S_LOAD: begin
        resp_rdata_d = load_extract(f3_q, lo_q, m_rdata);
        resp_valid_d = 1'b1;
        m_addr_d     = '0;
        state_d      = S_IDLE;
      end
      S_WRITE: begin
        resp_valid_d = 1'b1;
        m_addr_d     = '0;
        m_wdata_d    = 32'd0;
        state_d      = S_IDLE;
      end
      S_RMW_RD: begin
        // The old word is merged as it is captured, so the write cycle drives it directly.
        m_wdata_d = store_merge(f3_q[0], lo_q, m_rdata, wdata_q);
        m_we_d    = 1'b1;
        state_d   = S_RMW_WR;
      end
      S_RMW_WR: begin
        resp_valid_d = 1'b1;
        m_addr_d     = '0;
        m_wdata_d    = 32'd0;
        state_d      = S_IDLE;
      end
      default: begin
        m_addr_d  = '0;
        m_wdata_d = 32'd0;
        state_d   = S_IDLE;
      end
    endcase
  end

  // State and output registers; async reset drops m_we immediately
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= S_IDLE;
      f3_q         <= 3'd0;
      lo_q         <= 2'd0;
      wdata_q      <= 16'd0;
      resp_valid_q <= 1'b0;
      resp_err_q   <= 1'b0;
      resp_rdata_q <= 32'd0;
      m_addr_q     <= '0;
      m_wdata_q    <= 32'd0;
      m_we_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      f3_q         <= f3_d;
      lo_q         <= lo_d;
      wdata_q      <= wdata_d;
      resp_valid_q <= resp_valid_d;
      resp_err_q   <= resp_err_d;
      resp_rdata_q <= resp_rdata_d;
      m_addr_q     <= m_addr_d;
      m_wdata_q    <= m_wdata_d;
      m_we_q       <= m_we_d;
    end
  end

  assign req_ready  = (state_q == S_IDLE);
  assign resp_valid = resp_valid_q;
  assign resp_err   = resp_err_q;
  assign resp_rdata = resp_rdata_q;
  assign m_addr     = m_addr_q;
  assign m_wdata    = m_wdata_q;
  assign m_we       = m_we_q;

endmodule
